// File: rtl/wb_regfile.sv
// Purpose : MIPS write-back select plus 2**AW x DW architectural register file with two bypassed read ports.
// Latency : WB_wdata/WB_wen/ID_rdata* are combinational; a write commits on the next rising clk edge.
// Backpressure: none; a write is accepted on every edge where WB_wen=1 and rst=0.
//
// Ports:
//   clk, rst                 - pipeline clock, synchronous active-high reset (clears all registers)
//   WB_RegWrite/MemtoReg     - MEM/WB control: write enable, source select (1: load data, 0: ALU result)
//   WB_waddr/rdata/ALU_res   - MEM/WB destination register and candidate write-back values
//   ID_raddr1/2, ID_rdata1/2 - ID-stage read ports with write-to-read bypass
//   WB_wdata, WB_wen         - selected write-back value and qualified enable, for EX forwarding
//   dbg_addr, dbg_data       - raw stored contents, no bypass
module wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WB_RegWrite,
    input  logic          WB_MemtoReg,
    input  logic [AW-1:0] WB_waddr,
    input  logic [DW-1:0] WB_rdata,
    input  logic [DW-1:0] WB_ALU_res,
    input  logic [AW-1:0] ID_raddr1,
    input  logic [AW-1:0] ID_raddr2,
    output logic [DW-1:0] ID_rdata1,
    output logic [DW-1:0] ID_rdata2,
    output logic [DW-1:0] WB_wdata,
    output logic          WB_wen,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int NREG = 2 ** AW;

    // Packed so the whole file clears with a single '0 on reset.
    logic [NREG-1:0][DW-1:0] regs_q;
    logic [NREG-1:0][DW-1:0] regs_d;

    assign WB_wdata = WB_MemtoReg ? WB_rdata : WB_ALU_res;
    // $0 is hardwired zero, so a write to it is not a real write and must not bypass either.
    assign WB_wen   = WB_RegWrite && (WB_waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (WB_wen) begin
            regs_d[WB_waddr] = WB_wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass gives "write first half, read second half" semantics. WB_wen is deliberately
    // not gated by rst: reads still see the in-flight value during a reset cycle.
    function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] raddr);
        logic [DW-1:0] val;
        if (raddr == '0) begin
            val = '0;
        end else if (WB_wen && (raddr == WB_waddr)) begin
            val = WB_wdata;
        end else begin
            val = regs_q[raddr];
        end
        return val;
    endfunction

    assign ID_rdata1 = rd_port(ID_raddr1);
    assign ID_rdata2 = rd_port(ID_raddr2);
    assign dbg_data  = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule
